// File: rtl/bnn_seq_sched.sv
// rtl/bnn_seq_sched.sv - load/start/count/capture sequencer for the bit-serial BNN classifier core
// Optional build macro BNN_SCHED_PERF_EN adds perf_done/perf_busy counters.
module bnn_seq_sched #(
  parameter int N   = 16,
  parameter int M   = 40,
  parameter int B   = 4,
  parameter int C   = 10,
  parameter int LAT = N + M - 1,
  parameter int KW  = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B*N-1:0] in_data,
  output logic [B*N-1:0] core_data,
  output logic           core_rst,
  input  logic [KW-1:0]  core_klass,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [KW-1:0]  out_class,
  output logic           busy
`ifdef BNN_SCHED_PERF_EN
  ,
  output logic [15:0]    perf_done,
  output logic [31:0]    perf_busy
`endif
);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          run_last;
  logic          take_in;
  logic [KW-1:0] class_fix;

  assign run_last = (state == RUN) && (cnt == CW'(LAT - 1));
  assign take_in  = in_valid && in_ready;

  // Core numbers classes in reverse; out-of-range indices saturate to 0.
  assign class_fix = (core_klass > KW'(C - 1)) ? '0 : KW'(C - 1) - core_klass;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_rst  = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        core_rst = 1'b0;
        if (run_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      core_data <= '0;
      out_class <= '0;
    end else begin
      state <= state_nxt;
      if (take_in) core_data <= in_data;
      if (state == LOAD) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (run_last) out_class <= class_fix;
    end
  end

`ifdef BNN_SCHED_PERF_EN
  logic take_out;
  assign take_out = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_done <= '0;
      perf_busy <= '0;
    end else begin
      if (take_out) perf_done <= perf_done + 16'd1;
      if (busy && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bnn_seq_sched.sv
// tb/tb_bnn_seq_sched.sv - scoreboard bench for bnn_seq_sched
module tb_bnn_seq_sched;
  localparam int LAT = 55;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, core_rst, out_valid, out_ready, busy;
  logic [63:0] in_data, core_data;
  logic [3:0]  core_klass, out_class;
`ifdef BNN_SCHED_PERF_EN
  logic [15:0] perf_done;
  logic [31:0] perf_busy;
`endif

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, cons_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_next;

  bnn_seq_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_data(core_data), .core_rst(core_rst), .core_klass(core_klass),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .busy(busy)
`ifdef BNN_SCHED_PERF_EN
    , .perf_done(perf_done), .perf_busy(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: handshakes judged on pre-edge values, outputs observed 1ns after the edge.
  task automatic tick();
    logic acc, con, ov_prev;
    logic [3:0] oc;
    acc = rst && in_valid && in_ready;
    con = rst && out_valid && out_ready;
    oc = out_class;
    ov_prev = out_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      exp_q.push_back(exp_next);
      acc_cyc = cyc;
      acc_cnt++;
    end
    if (con) begin
      cons_cnt++;
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("class", oc, exp_q.pop_front());
    end
    if (out_valid && !ov_prev) begin
      chk("valid_pending", exp_q.size() > 0, 1);
      chk("latency", cyc - acc_cyc, LAT + 1);
    end
    if (busy) chk("rdy_busy", in_ready, 0);
  endtask

  task automatic wait_acc();
    int a0, n;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 200) begin tick(); n++; end
    chk("acc_timeout", acc_cnt != a0, 1);
  endtask

  task automatic wait_cons();
    int c0, n;
    c0 = cons_cnt;
    n = 0;
    while (cons_cnt == c0 && n < 200) begin tick(); n++; end
    chk("cons_timeout", cons_cnt != c0, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("valid_timeout", out_valid, 1);
  endtask

  task automatic run_sample(input logic [63:0] d, input logic [3:0] k, input logic [3:0] e);
    in_data = d;
    core_klass = k;
    exp_next = e;
    in_valid = 1'b1;
    wait_acc();
    chk("core_data_acc", core_data, d);
    chk("load_rst", core_rst, 1);
  endtask

  logic [63:0] b2b_d[5] = '{64'h8f4d96400498fe6f, 64'h0e4f7c572260b0f1, 64'h095bceffcc884430,
                            64'h0f1f1b37e5f7c4b0, 64'h0b8dffddaa665380};
  logic [3:0]  b2b_k[5] = '{4'd0, 4'd9, 4'd4, 4'd1, 4'd7};
  logic [3:0]  b2b_e[5] = '{4'd9, 4'd0, 4'd5, 4'd8, 4'd2};

  initial begin
    int prev, lows, n, vcnt;
    rst = 1'b0;
    prev = 0;
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      in_data = {$urandom, $urandom};
      core_klass = 4'($urandom);
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_core_data", core_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_class", out_class, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    core_klass = '0;
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back run, in_valid held high
    for (int i = 0; i < 5; i++) begin
      run_sample(b2b_d[i], b2b_k[i], b2b_e[i]);
      if (i > 0) chk("spacing", acc_cyc - prev, LAT + 3);
      prev = acc_cyc;
      wait_cons();
    end
    in_valid = 1'b0;
`ifdef BNN_SCHED_PERF_EN
    chk("perf_done", perf_done, 5);
    chk("perf_busy", perf_busy, 5 * 57);
`endif
    tick();

    // Single sample with core_rst window measurement
    run_sample(64'h8f4d96400498fe6f, 4'd3, 4'd6);
    in_valid = 1'b0;
    lows = 0;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
      if (!core_rst) lows++;
    end
    chk("rst_low_cycles", lows, LAT);
    chk("single_valid", out_valid, 1);
    chk("single_class", out_class, 6);
    chk("single_core_data", core_data, 64'h8f4d96400498fe6f);
    wait_cons();

    // Backpressure in DONE
    out_ready = 1'b0;
    run_sample(64'h0e4f7c572260b0f1, 4'd2, 4'd7);
    in_valid = 1'b0;
    wait_valid();
    in_data = 64'hdeadbeefcafef00d;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_class", out_class, 7);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_core_data", core_data, 64'h0e4f7c572260b0f1);
    end
    out_ready = 1'b1;
    wait_cons();
    in_valid = 1'b0;
    tick();

    // Reset mid-RUN
    run_sample(64'h095bceffcc884430, 4'd5, 4'd4);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) tick();
    chk("mid_in_run", core_rst, 0);
    rst = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_core_rst", core_rst, 1);
    chk("mid_busy", busy, 0);
    chk("mid_core_data", core_data, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid) vcnt++;
    end
    chk("no_valid_after_abort", vcnt, 0);
    run_sample(64'h0f1f1b37e5f7c4b0, 4'd8, 4'd1);
    in_valid = 1'b0;
    wait_cons();

    // Out-of-range class saturates to 0
    run_sample(64'h0b8dffddaa665380, 4'd15, 4'd0);
    in_valid = 1'b0;
    wait_cons();
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bnn_seq_sched.md
# bnn_seq_sched

Sequencing controller for the bit-serial BNN classifier core. Accepts one B*N-bit feature word per valid/ready handshake and holds it on the core's data input. It then drives the core's reset/start pulse, counts the fixed N+M-1 cycle compute window, and captures the core's class index. The result is presented as a corrected class on a valid/ready output. It sits between the sample source (FIFO or host register file) and the sequential classifier, replacing the fixed-delay driving that the bench does today.

## Interface
- N, 16, input features per sample
- M, 40, hidden neurons (sets compute length)
- B, 4, bits per feature
- C, 10, number of classes
- LAT, N+M-1, core compute cycles after core reset release; must be ≥1
- KW, $clog2(C), class index width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  scheduler can accept a sample
- in_data  in  B*N  feature word
- core_data  out  B*N  registered feature word to the core
- core_rst  out  1  active-high reset/start to the core
- core_klass  in  KW  raw class index from the core
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_class  out  KW  corrected class, C-1-core_klass
- busy  out  1  high in LOAD, RUN, DONE

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1, core_rst=1.
  - On in_valid&&in_ready: core_data<=in_data, go to LOAD.
- LOAD:
  - core_rst=1 for exactly one cycle with core_data stable.
  - Run counter <=0. Go to RUN.
- RUN:
  - core_rst=0.
  - Counter increments each cycle.
  - When counter==LAT-1: latch out_class, go to DONE.
- DONE:
  - out_valid=1, core_rst=1.
  - out_class is held stable until out_valid&&out_ready, then go to IDLE.
- Arithmetic rules:
  - out_class = C-1-core_klass, computed in KW bits.
  - If core_klass > C-1, out_class is 0 (saturate, no underflow).
- Counter width is $clog2(LAT+1). Wrap-around cannot occur.
- core_data changes only on an accepted handshake. It is stable through LOAD, RUN and DONE.
- in_ready is 0 outside IDLE. No second sample is accepted while a classification is in flight.
- in_valid without in_ready has no effect. in_data may change freely while in_ready=0.
- out_ready while out_valid=0 is ignored.

## Timing
- Reset (rst low, asynchronous, any state):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_class=0, core_data=0, core_rst=1, busy=0, counter=0.
- Reset mid-RUN aborts the classification. No result is emitted.
- Handshake accepted at edge k:
  - LOAD occupies cycle k..k+1.
  - RUN occupies LAT cycles.
  - out_valid rises after edge k+LAT+1.
  - Defaults (LAT=55): out_valid high 56 cycles after acceptance.
- Result consumed at edge j: out_valid=0 and in_ready=1 after edge j.
- Minimum sample period is LAT+3 cycles (58 at defaults), with in_valid and out_ready tied high.
- core_klass is sampled only at the final RUN edge. Its value at other times is don't-care.

## Configuration
- BNN_SCHED_PERF_EN defined: adds two output ports.
  - perf_done (out, 16): count of results consumed, wraps at 2^16.
  - perf_busy (out, 32): count of cycles with busy=1, saturates at 2^32-1.
  - Both counters reset to 0 on rst low.
- BNN_SCHED_PERF_EN undefined:
  - Ports and counters are absent.
  - All other behaviour is identical, cycle for cycle.

## Test plan
- Reset check: hold rst low with random inputs. Required: in_ready=1, out_valid=0, core_rst=1, core_data=0. Then release rst.
- Single sample: in_data=64'h8f4d96400498fe6f, core stub returns core_klass=3 at end of window, out_ready=1. Required:
  - core_data matches in_data from the cycle after acceptance.
  - core_rst is high exactly one cycle, then low 55 cycles.
  - out_valid is high at cycle 56 after acceptance, with out_class=6.
- Back-to-back run: five samples 64'h8f4d96400498fe6f, 64'h0e4f7c572260b0f1, 64'h095bceffcc884430, 64'h0f1f1b37e5f7c4b0, 64'h0b8dffddaa665380 with stub klass 0,9,4,1,7, in_valid held high. Required:
  - out_class 9,0,5,8,2, in order.
  - Acceptances spaced 58 cycles apart.
  - in_ready=0 whenever busy=1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE with klass=2. Required:
  - out_class=7 stays stable, out_valid stays 1, in_ready stays 0.
  - core_data is unchanged despite a new in_data and in_valid=1.
- Reset mid-RUN: assert rst low at RUN cycle 30. Required:
  - Immediate IDLE outputs; no out_valid pulse follows.
  - Next sample completes normally with the full 56-cycle latency.
- Edge class and perf: stub klass=15 (invalid). Required: out_class=0.
  - With BNN_SCHED_PERF_EN defined, after the five-sample run: perf_done=5, perf_busy=5*57=285 with out_ready high.
